// File: rtl/univ_shift_reg.sv
// Universal shift register: clear/set/parallel load plus SHL/SHR/ROL/ROR/ASR,
// with a saturating shift counter and a done pulse that marks each WIDTH-bit frame.
module univ_shift_reg #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned LOAD_SVALUE = 4,
    parameter int unsigned RST_VALUE   = 0,
    parameter int unsigned CNT_W       = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sclr,
    input  logic             sset,
    input  logic             load,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             shiftin_l,
    input  logic             shiftin_r,
    output logic [WIDTH-1:0] q,
    output logic             shiftout_l,
    output logic             shiftout_r,
    output logic [CNT_W-1:0] shift_cnt,
    output logic             done
);

    typedef enum logic [2:0] {
        MODE_HOLD = 3'b000,
        MODE_SHL  = 3'b001,
        MODE_SHR  = 3'b010,
        MODE_ROL  = 3'b011,
        MODE_ROR  = 3'b100,
        MODE_ASR  = 3'b101
    } mode_e;

    logic [WIDTH-1:0] shifted;
    logic             is_shift;

    // Next shift result; reserved encodings fall through to hold
    always_comb begin
        shifted  = q;
        is_shift = 1'b0;
        case (mode)
            MODE_SHL: begin
                shifted  = {q[WIDTH-2:0], shiftin_r};
                is_shift = 1'b1;
            end
            MODE_SHR: begin
                shifted  = {shiftin_l, q[WIDTH-1:1]};
                is_shift = 1'b1;
            end
            MODE_ROL: begin
                shifted  = {q[WIDTH-2:0], q[WIDTH-1]};
                is_shift = 1'b1;
            end
            MODE_ROR: begin
                shifted  = {q[0], q[WIDTH-1:1]};
                is_shift = 1'b1;
            end
            MODE_ASR: begin
                shifted  = {q[WIDTH-1], q[WIDTH-1:1]};
                is_shift = 1'b1;
            end
            default: begin
                shifted  = q;
                is_shift = 1'b0;
            end
        endcase
    end

    // Register, counter and done pulse; done fires only on the WIDTH-1 -> WIDTH step
    always_ff @(posedge clk) begin
        if (rst) begin
            q         <= WIDTH'(RST_VALUE);
            shift_cnt <= '0;
            done      <= 1'b0;
        end else if (!en) begin
            done <= 1'b0;
        end else if (sclr) begin
            q         <= '0;
            shift_cnt <= '0;
            done      <= 1'b0;
        end else if (sset) begin
            q         <= WIDTH'(LOAD_SVALUE);
            shift_cnt <= '0;
            done      <= 1'b0;
        end else if (load) begin
            q         <= d;
            shift_cnt <= '0;
            done      <= 1'b0;
        end else begin
            q    <= shifted;
            done <= 1'b0;
            if (is_shift && (shift_cnt < CNT_W'(WIDTH))) begin
                shift_cnt <= shift_cnt + CNT_W'(1);
                done      <= (shift_cnt == CNT_W'(WIDTH - 1));
            end
        end
    end

    assign shiftout_l = q[WIDTH-1];
    assign shiftout_r = q[0];

endmodule
